video_contrast_adjust: RTL and testbench
========================================

Name: video_contrast_adjust

Overview:
Parametrised multi-channel contrast/brightness stage for the video pipeline. Each channel is processed as out = sat(round(in * gain / 2^FRAC_W) + offset).
- Gain and offset are programmable.
- Configuration is double-buffered and committed only at frame start, so a frame never shows mixed settings.
- Sits between the timing generator / pattern source and the HDMI encoder. Video timing signals are delayed to stay aligned with the pixel data.

Parameters:
DATA_W, 8, bits per colour channel
CH, 3, number of channels packed in the data bus (channel 0 in LSBs)
GAIN_W, 5, unsigned gain width
FRAC_W, 2, fractional bits of gain (gain 2^FRAC_W = unity); FRAC_W < GAIN_W
OFS_W, 9, signed offset width, two's complement; OFS_W <= DATA_W+1

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
vs_in  in  1  vertical sync, active-high
hs_in  in  1  horizontal sync, active-high
de_in  in  1  data enable
data_in  in  CH*DATA_W  packed pixel
cfg_valid  in  1  one-cycle strobe: capture cfg_gain/cfg_offset/cfg_bypass into pending
cfg_gain  in  GAIN_W  unsigned fixed-point gain
cfg_offset  in  OFS_W  signed brightness offset
cfg_bypass  in  1  1 = pass pixel unchanged
vs_out  out  1  vs_in delayed 3 cycles
hs_out  out  1  hs_in delayed 3 cycles
de_out  out  1  de_in delayed 3 cycles
data_out  out  CH*DATA_W  processed pixel
cfg_applied  out  1  one-cycle pulse: pending config committed to active

Behaviour:
- Reset (async assert, sync-free deassert handled upstream):
  - All outputs 0; all pipeline registers 0.
  - Active and pending gain = 2^FRAC_W, offset = 0, bypass = 0.
  - pending_flag = 0.
- Config path:
  - cfg_valid=1: pending <= cfg_*, pending_flag <= 1. A later cfg_valid before commit overwrites pending (last write wins).
  - Frame start is the vs_in rising edge: vs_in=1 with registered vs_in_d=0.
  - At frame start with pending_flag=1: active <= pending, pending_flag <= 0, cfg_applied=1 the next cycle.
  - cfg_valid in the same cycle as frame start: the commit uses the old pending contents. The new values land in pending with pending_flag=1 and are committed at the following frame start. cfg_applied still pulses for the old commit.
  - Frame start with pending_flag=0: no change, no pulse.
- Pipeline: fixed 3-cycle latency, independent of bypass and of de.
  - S1: per channel, prod = data_ch * active_gain (DATA_W+GAIN_W bits, unsigned). Pixel and bypass are registered alongside.
  - S2: scl = (prod + 2^(FRAC_W-1)) >> FRAC_W, round-half-up; no rounding term when FRAC_W=0. sum = scl + sign-extended offset, signed, DATA_W+GAIN_W-FRAC_W+2 bits, no overflow possible.
  - S3 saturation:
    - sum < 0 -> 0
    - sum > 2^DATA_W-1 -> 2^DATA_W-1
    - otherwise sum[DATA_W-1:0]
    - bypass -> S1-registered pixel
- Blanking: if de at S3 = 0, data_out = 0.
- Sync outputs are pure 3-stage shift registers of vs/hs/de.
- Active config is sampled at S1. A commit therefore affects pixels entering S1 in the cycle after frame start. Pixels already in flight keep the old config.
- Channels are processed identically and independently with the same gain/offset. There is no cross-channel interaction.
- Continuous streaming: a new pixel is accepted every cycle, with no stalls and no backpressure.

Test Plan:
- Reset, then stream with defaults (gain 4, offset 0), data_in=0x64C8FF, de=1 -> data_out=0x64C8FF 3 cycles later; vs/hs/de_out equal the inputs delayed exactly 3 cycles.
- cfg gain=6 (1.5), offset=0, then vs pulse; pixel 0x0164C8 -> 0x0296FF: ch2 1*1.5=1.5 rounds to 2, ch1 150, ch0 300 saturates to 255. cfg_applied pulses once, one cycle after the vs rise.
- gain=4, offset=-20 (9'h1EC), pixels 10 and 100 -> 0 (negative clamp) and 80. offset=+255 with pixel 200 -> 255.
- cfg_valid mid-frame (gain=0) -> output unchanged until the next vs rise, then all channels 0. cfg_valid coincident with the vs rise -> the old pending is applied, and the new value only after the following vs rise.
- cfg_bypass=1 with gain=7, offset=+50, committed -> data_out equals data_in with 3-cycle latency. de_in=0 cycles -> data_out=0 regardless of data_in.
- Assert rst mid-line with gain=6 active -> all outputs 0 immediately. After release, with no cfg write, pixel 100 -> 100 (unity restored).

Source files
------------

// File: rtl/video_contrast_adjust.sv
// video_contrast_adjust: per-channel out = sat(round(in*gain/2^FRAC_W) + offset) with frame-synchronous
// config commit; vs/hs/de delayed 3 cycles to stay aligned with the pixel data.
module video_contrast_adjust #(
   parameter int DATA_W = 8,
   parameter int CH     = 3,
   parameter int GAIN_W = 5,
   parameter int FRAC_W = 2,
   parameter int OFS_W  = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vs_in,
   input  logic                 hs_in,
   input  logic                 de_in,
   input  logic [CH*DATA_W-1:0] data_in,
   input  logic                 cfg_valid,
   input  logic [GAIN_W-1:0]    cfg_gain,
   input  logic [OFS_W-1:0]     cfg_offset,
   input  logic                 cfg_bypass,
   output logic                 vs_out,
   output logic                 hs_out,
   output logic                 de_out,
   output logic [CH*DATA_W-1:0] data_out,
   output logic                 cfg_applied
);
   localparam int PW = DATA_W + GAIN_W;
   localparam int SW = DATA_W + GAIN_W - FRAC_W + 2;
   localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << FRAC_W;
   localparam logic [PW:0] HALF = ((PW+1)'(1) << FRAC_W) >> 1;
   localparam logic [SW-1:0] MAXV = SW'((1 << DATA_W) - 1);

   logic [2:0] vs_q, hs_q, de_q;
   logic [GAIN_W-1:0] pend_gain_q, pend_gain_d, act_gain_q, act_gain_d;
   logic [OFS_W-1:0] pend_ofs_q, pend_ofs_d, act_ofs_q, act_ofs_d, ofs1_q;
   logic pend_byp_q, pend_byp_d, act_byp_q, act_byp_d, pend_flag_q, pend_flag_d;
   logic frame_start, commit, applied_q, byp1_q, byp2_q;
   logic [CH-1:0][PW-1:0] prod_q, prod_d;
   logic [CH-1:0][SW-1:0] sum_q, sum_d;
   logic [CH*DATA_W-1:0] pix1_q, pix2_q, data_q, data_d;

   // vs_q[0] doubles as the registered vs used for frame-start detection
   always_comb begin
      frame_start = vs_in & ~vs_q[0];
      commit      = frame_start & pend_flag_q;
      pend_gain_d = cfg_valid ? cfg_gain : pend_gain_q;
      pend_ofs_d  = cfg_valid ? cfg_offset : pend_ofs_q;
      pend_byp_d  = cfg_valid ? cfg_bypass : pend_byp_q;
      pend_flag_d = cfg_valid | (pend_flag_q & ~frame_start);
      act_gain_d  = commit ? pend_gain_q : act_gain_q;
      act_ofs_d   = commit ? pend_ofs_q : act_ofs_q;
      act_byp_d   = commit ? pend_byp_q : act_byp_q;
      for (int c = 0; c < CH; c++) begin
         prod_d[c] = PW'(data_in[c*DATA_W +: DATA_W]) * PW'(act_gain_q);
         sum_d[c]  = SW'(({1'b0, prod_q[c]} + HALF) >> FRAC_W) + SW'($signed(ofs1_q));
         data_d[c*DATA_W +: DATA_W] = !de_q[1] ? '0 :
                                      byp2_q ? pix2_q[c*DATA_W +: DATA_W] :
                                      sum_q[c][SW-1] ? '0 :
                                      (sum_q[c] > MAXV) ? DATA_W'(MAXV) : sum_q[c][DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q        <= '0;
         hs_q        <= '0;
         de_q        <= '0;
         pend_gain_q <= UNITY;
         pend_ofs_q  <= '0;
         pend_byp_q  <= 1'b0;
         pend_flag_q <= 1'b0;
         act_gain_q  <= UNITY;
         act_ofs_q   <= '0;
         act_byp_q   <= 1'b0;
         applied_q   <= 1'b0;
         prod_q      <= '0;
         pix1_q      <= '0;
         byp1_q      <= 1'b0;
         ofs1_q      <= '0;
         sum_q       <= '0;
         pix2_q      <= '0;
         byp2_q      <= 1'b0;
         data_q      <= '0;
      end else begin
         vs_q        <= {vs_q[1:0], vs_in};
         hs_q        <= {hs_q[1:0], hs_in};
         de_q        <= {de_q[1:0], de_in};
         pend_gain_q <= pend_gain_d;
         pend_ofs_q  <= pend_ofs_d;
         pend_byp_q  <= pend_byp_d;
         pend_flag_q <= pend_flag_d;
         act_gain_q  <= act_gain_d;
         act_ofs_q   <= act_ofs_d;
         act_byp_q   <= act_byp_d;
         applied_q   <= commit;
         prod_q      <= prod_d;
         pix1_q      <= data_in;
         byp1_q      <= act_byp_q;
         ofs1_q      <= act_ofs_q;
         sum_q       <= sum_d;
         pix2_q      <= pix1_q;
         byp2_q      <= byp1_q;
         data_q      <= data_d;
      end
   end

   assign vs_out      = vs_q[2];
   assign hs_out      = hs_q[2];
   assign de_out      = de_q[2];
   assign data_out    = data_q;
   assign cfg_applied = applied_q;
endmodule

// File: tb/tb_video_contrast_adjust.sv
// tb_video_contrast_adjust: directed stimulus with hand-computed pixels; a negedge monitor
// pops expected outputs from cycle-tagged queues and compares them.
module tb_video_contrast_adjust;
   logic clk = 0, rst = 1, vs_in = 0, hs_in = 0, de_in = 0;
   logic cfg_valid = 0, cfg_bypass = 0;
   logic [23:0] data_in = '0;
   logic [4:0] cfg_gain = 5'd4;
   logic [8:0] cfg_offset = '0;
   logic vs_out, hs_out, de_out, cfg_applied;
   logic [23:0] data_out;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   logic prev_vs = 0, pflag = 0;

   typedef struct {int cyc; logic [23:0] d; logic [2:0] s;} dexp_t;
   typedef struct {int cyc; logic a;} aexp_t;
   dexp_t dq[$];
   aexp_t aq[$];
   dexp_t me;
   aexp_t ma;

   video_contrast_adjust dut (
      .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .data_in(data_in),
      .cfg_valid(cfg_valid), .cfg_gain(cfg_gain), .cfg_offset(cfg_offset), .cfg_bypass(cfg_bypass),
      .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .data_out(data_out), .cfg_applied(cfg_applied)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   always @(negedge clk) if (!rst) begin
      while (dq.size() > 0 && dq[0].cyc <= cyc) begin
         me = dq.pop_front();
         chk("data", 32'(data_out), 32'(me.d));
         chk("sync", 32'({vs_out, hs_out, de_out}), 32'(me.s));
      end
      while (aq.size() > 0 && aq[0].cyc <= cyc) begin
         ma = aq.pop_front();
         chk("cfg_applied", 32'(cfg_applied), 32'(ma.a));
      end
   end

   task automatic cfg(input logic [4:0] g, input logic [8:0] o, input logic b);
      cfg_valid = 1; cfg_gain = g; cfg_offset = o; cfg_bypass = b;
   endtask

   task automatic step(input logic vs, input logic hs, input logic de,
                       input logic [23:0] d, input logic [23:0] exp);
      logic fs;
      dexp_t e;
      aexp_t a;
      vs_in = vs; hs_in = hs; de_in = de; data_in = d;
      fs = vs & ~prev_vs;
      a.cyc = cyc + 1; a.a = fs & pflag;
      aq.push_back(a);
      e.cyc = cyc + 3; e.d = exp; e.s = {vs, hs, de};
      dq.push_back(e);
      pflag = cfg_valid | (pflag & ~fs);
      prev_vs = vs;
      @(posedge clk);
      #1 cfg_valid = 0;
   endtask

   initial begin
      @(posedge clk); #1;
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_sync", 32'({vs_out, hs_out, de_out}), 32'h0);
      chk("rst_app", 32'(cfg_applied), 32'h0);
      rst = 0;
      // defaults: unity gain, zero offset; vs rise with nothing pending gives no pulse
      step(0, 1, 0, 24'h64C8FF, 24'h000000);
      step(0, 0, 1, 24'h64C8FF, 24'h64C8FF);
      step(0, 0, 1, 24'h123456, 24'h123456);
      step(1, 0, 0, 24'hAAAAAA, 24'h000000);
      step(0, 1, 1, 24'h64C8FF, 24'h64C8FF);
      // gain 1.5: the pixel entering on the vs rise still uses the old setting
      cfg(5'd6, 9'd0, 0); step(0, 0, 1, 24'h0164C8, 24'h0164C8);
      step(1, 0, 1, 24'h0164C8, 24'h0164C8);
      step(1, 0, 1, 24'h0164C8, 24'h0296FF);
      step(0, 1, 0, 24'h0164C8, 24'h000000);
      // offset -20: negative clamp and exact-zero boundary
      cfg(5'd4, 9'h1EC, 0); step(0, 0, 0, 24'h0, 24'h0);
      step(1, 0, 0, 24'h0, 24'h0);
      step(0, 0, 1, 24'h0A640A, 24'h005000);
      step(0, 0, 1, 24'h14150A, 24'h000100);
      // offset +255: high clamp
      cfg(5'd4, 9'h0FF, 0); step(0, 0, 0, 24'h0, 24'h0);
      step(1, 0, 0, 24'h0, 24'h0);
      step(0, 0, 1, 24'hC80100, 24'hFFFFFF);
      step(0, 0, 1, 24'h000000, 24'hFFFFFF);
      // mid-frame write of gain 0 waits for the next vs rise
      cfg(5'd0, 9'd0, 0); step(0, 0, 1, 24'h000000, 24'hFFFFFF);
      step(0, 0, 1, 24'h102030, 24'hFFFFFF);
      step(1, 0, 1, 24'h64C8FF, 24'hFFFFFF);
      step(0, 0, 1, 24'h64C8FF, 24'h000000);
      // write coincident with vs rise: old pending (unity) now, gain 2 next frame
      cfg(5'd4, 9'd0, 0); step(0, 0, 1, 24'h102040, 24'h000000);
      cfg(5'd8, 9'd0, 0); step(1, 0, 1, 24'h102040, 24'h000000);
      step(1, 0, 1, 24'h102040, 24'h102040);
      step(0, 0, 1, 24'h102040, 24'h102040);
      step(1, 0, 0, 24'h0, 24'h0);
      step(0, 0, 1, 24'h102040, 24'h204080);
      step(0, 0, 1, 24'h7F8001, 24'hFEFF02);
      // bypass ignores gain/offset; blanking zeroes data
      cfg(5'd7, 9'd50, 1); step(0, 0, 0, 24'h0, 24'h0);
      step(1, 0, 0, 24'h0, 24'h0);
      step(0, 1, 1, 24'h64C8FF, 24'h64C8FF);
      step(0, 0, 1, 24'h010203, 24'h010203);
      step(0, 0, 0, 24'hFFFFFF, 24'h000000);
      step(0, 1, 0, 24'h123456, 24'h000000);
      // gain 1.5 active, then reset mid-line
      cfg(5'd6, 9'd0, 0); step(0, 0, 0, 24'h0, 24'h0);
      step(1, 0, 0, 24'h0, 24'h0);
      step(0, 0, 1, 24'h000010, 24'h000018);
      step(0, 0, 1, 24'h646464, 24'h969696);
      step(0, 1, 1, 24'h646464, 24'h969696);
      #2 rst = 1;
      #1;
      chk("midrst_data", 32'(data_out), 32'h0);
      chk("midrst_sync", 32'({vs_out, hs_out, de_out}), 32'h0);
      chk("midrst_app", 32'(cfg_applied), 32'h0);
      dq.delete(); aq.delete();
      pflag = 0; prev_vs = 0;
      vs_in = 0; hs_in = 0; de_in = 0; data_in = '0;
      @(posedge clk); #1 rst = 0;
      step(0, 0, 1, 24'h646464, 24'h646464);
      step(0, 0, 1, 24'h0164C8, 24'h0164C8);
      repeat (4) step(0, 0, 0, 24'h0, 24'h0);
      repeat (4) @(negedge clk);
      #1 chk("drain", 32'(dq.size() + aq.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
